// File: rtl/acc_alu_ctrl.sv
// Accumulator-based datapath slice: opcode decode, 8-bit ALU and the accumulator register.
// Decode and ALU are combinational; only the accumulator holds state.
module acc_alu_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [4:0] immediate,
   input  logic [7:0] reg_data,
   input  logic [7:0] pc_addr,
   output logic [7:0] acc_out,
   output logic [7:0] alu_out,
   output logic       alu_zero,
   output logic       alu_carry,
   output logic [1:0] cntr_alu,
   output logic       regWE,
   output logic       memWE,
   output logic       accWE,
   output logic       brnch,
   output logic       lw,
   output logic       alu_sc,
   output logic       acc_sc,
   output logic       mem_sc
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_LDI  = 3'b010;
   localparam logic [2:0] OP_MOVA = 3'b011;
   localparam logic [2:0] OP_LW   = 3'b100;
   localparam logic [2:0] OP_SW   = 3'b101;
   localparam logic [2:0] OP_JAL  = 3'b110;
   localparam logic [2:0] OP_AND  = 3'b111;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_LINK = 2'b11;

   logic [7:0] acc_q, acc_d;
   logic       reg_we_raw, mem_we_raw, acc_we_raw, brnch_raw;
   logic [7:0] alu_b;
   logic [7:0] imm_ext;
   logic [8:0] alu_wide;

   always_comb begin
      cntr_alu   = ALU_ADD;
      reg_we_raw = 1'b0;
      mem_we_raw = 1'b0;
      acc_we_raw = 1'b0;
      brnch_raw  = 1'b0;
      lw         = 1'b0;
      alu_sc     = 1'b0;
      acc_sc     = 1'b0;
      mem_sc     = 1'b0;
      case (opcode)
         OP_ADD:  begin cntr_alu = ALU_ADD; reg_we_raw = 1'b1; alu_sc = 1'b1; end
         OP_SUB:  begin cntr_alu = ALU_SUB; reg_we_raw = 1'b1; alu_sc = 1'b1; end
         OP_LDI:  begin acc_we_raw = 1'b1; acc_sc = 1'b1; end
         OP_MOVA: begin acc_we_raw = 1'b1; end
         OP_LW:   begin reg_we_raw = 1'b1; lw = 1'b1; mem_sc = 1'b1; end
         OP_SW:   begin mem_we_raw = 1'b1; mem_sc = 1'b1; end
         OP_JAL:  begin brnch_raw = 1'b1; reg_we_raw = 1'b1; cntr_alu = ALU_LINK; end
         OP_AND:  begin cntr_alu = ALU_AND; reg_we_raw = 1'b1; alu_sc = 1'b1; end
         default: ;
      endcase
   end

   // Side-effecting enables are suppressed while reset is held; steering selects are not.
   assign regWE = reg_we_raw & ~reset;
   assign memWE = mem_we_raw & ~reset;
   assign accWE = acc_we_raw & ~reset;
   assign brnch = brnch_raw  & ~reset;

   assign alu_b   = alu_sc ? reg_data : 8'h00;
   assign imm_ext = {{3{immediate[4]}}, immediate};

   always_comb begin
      alu_wide = 9'd0;
      case (cntr_alu)
         ALU_ADD:  alu_wide = {1'b0, acc_q} + {1'b0, alu_b};
         ALU_SUB:  alu_wide = {1'b0, acc_q} - {1'b0, alu_b};
         ALU_AND:  alu_wide = {1'b0, acc_q & alu_b};
         ALU_LINK: alu_wide = {1'b0, pc_addr + 8'd1};
         default:  alu_wide = 9'd0;
      endcase
   end

   // Bit 8 of the 9-bit sum/difference is the carry (ADD) or borrow (SUB).
   assign alu_out   = alu_wide[7:0];
   assign alu_carry = (cntr_alu == ALU_ADD || cntr_alu == ALU_SUB) ? alu_wide[8] : 1'b0;
   assign alu_zero  = (alu_wide[7:0] == 8'h00);

   assign acc_d = accWE ? (acc_sc ? imm_ext : reg_data) : acc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) acc_q <= 8'h00;
      else       acc_q <= acc_d;
   end

   assign acc_out = acc_q;

endmodule

// File: tb/tb_acc_alu_ctrl.sv
// Directed bench for acc_alu_ctrl: decode table, ALU results/flags, accumulator loads and reset behaviour.
module tb_acc_alu_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] opcode;
   logic [4:0] immediate;
   logic [7:0] reg_data;
   logic [7:0] pc_addr;
   logic [7:0] acc_out;
   logic [7:0] alu_out;
   logic       alu_zero;
   logic       alu_carry;
   logic [1:0] cntr_alu;
   logic       regWE, memWE, accWE, brnch, lw, alu_sc, acc_sc, mem_sc;

   int n_tests = 0;
   int n_fail  = 0;

   acc_alu_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .immediate(immediate),
      .reg_data(reg_data), .pc_addr(pc_addr), .acc_out(acc_out), .alu_out(alu_out),
      .alu_zero(alu_zero), .alu_carry(alu_carry), .cntr_alu(cntr_alu),
      .regWE(regWE), .memWE(memWE), .accWE(accWE), .brnch(brnch), .lw(lw),
      .alu_sc(alu_sc), .acc_sc(acc_sc), .mem_sc(mem_sc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge, landing 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ldi(input logic [4:0] imm);
      opcode    = 3'b010;
      immediate = imm;
      tick();
   endtask

   // {regWE, memWE, accWE, brnch, lw, alu_sc, acc_sc, mem_sc}
   function automatic logic [7:0] ctl_vec();
      return {regWE, memWE, accWE, brnch, lw, alu_sc, acc_sc, mem_sc};
   endfunction

   logic [7:0] exp_ctl [8];
   logic [1:0] exp_alu [8];

   initial begin
      exp_ctl[0] = 8'b1000_0100; exp_alu[0] = 2'b00; // ADD
      exp_ctl[1] = 8'b1000_0100; exp_alu[1] = 2'b01; // SUB
      exp_ctl[2] = 8'b0010_0010; exp_alu[2] = 2'b00; // LDI
      exp_ctl[3] = 8'b0010_0000; exp_alu[3] = 2'b00; // MOVA
      exp_ctl[4] = 8'b1000_1001; exp_alu[4] = 2'b00; // LW
      exp_ctl[5] = 8'b0100_0001; exp_alu[5] = 2'b00; // SW
      exp_ctl[6] = 8'b1001_0000; exp_alu[6] = 2'b11; // JAL
      exp_ctl[7] = 8'b1000_0100; exp_alu[7] = 2'b10; // AND

      reset = 1'b1; opcode = 3'b000; immediate = 5'd0; reg_data = 8'h00; pc_addr = 8'h00;
      #2;
      check("reset_acc", acc_out, 8'h00);
      for (int i = 0; i < 8; i++) begin
         opcode = 3'(i);
         #1;
         check($sformatf("rst_we_op%0d", i), {4'h0, regWE, memWE, accWE, brnch}, 8'h00);
         check($sformatf("rst_sel_op%0d", i), {4'h0, lw, alu_sc, acc_sc, mem_sc}, {4'h0, exp_ctl[i][3:0]});
      end

      // LDI presented while reset high: edge must not load.
      opcode = 3'b010; immediate = 5'b00101;
      tick();
      check("rst_blocks_load", acc_out, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("after_rst_acc", acc_out, 8'h00);

      for (int i = 0; i < 8; i++) begin
         opcode = 3'(i);
         #1;
         check($sformatf("decode_op%0d", i), ctl_vec(), exp_ctl[i]);
         check($sformatf("cntr_op%0d", i), {6'h0, cntr_alu}, {6'h0, exp_alu[i]});
      end

      load_ldi(5'b00101); check("ldi_05", acc_out, 8'h05);
      load_ldi(5'b11111); check("ldi_ff", acc_out, 8'hFF);
      load_ldi(5'b10000); check("ldi_f0", acc_out, 8'hF0);
      load_ldi(5'b01111); check("ldi_0f", acc_out, 8'h0F);

      load_ldi(5'b00101);
      reg_data = 8'h03;
      opcode = 3'b000; #1;
      check("add_out", alu_out, 8'h08);
      check("add_flags", {6'h0, alu_zero, alu_carry}, 8'h00);
      opcode = 3'b001; #1;
      check("sub_out", alu_out, 8'h02);
      check("sub_carry", {7'h0, alu_carry}, 8'h00);
      opcode = 3'b111; #1;
      check("and_out", alu_out, 8'h01);
      check("and_carry", {7'h0, alu_carry}, 8'h00);
      tick();
      check("acc_hold", acc_out, 8'h05);

      load_ldi(5'b00011);
      reg_data = 8'h05; opcode = 3'b001; #1;
      check("sub_borrow_out", alu_out, 8'hFE);
      check("sub_borrow_c", {7'h0, alu_carry}, 8'h01);

      load_ldi(5'b11111);
      reg_data = 8'h01; opcode = 3'b000; #1;
      check("add_wrap_out", alu_out, 8'h00);
      check("add_wrap_flags", {6'h0, alu_zero, alu_carry}, 8'h03);

      opcode = 3'b110; pc_addr = 8'hFF; #1;
      check("jal_ff_out", alu_out, 8'h00);
      check("jal_ff_ctl", {5'h0, brnch, regWE, alu_carry}, 8'h06);
      pc_addr = 8'h10; #1;
      check("jal_10_out", alu_out, 8'h11);

      opcode = 3'b011; reg_data = 8'hA5;
      tick();
      check("mova_a5", acc_out, 8'hA5);

      opcode = 3'b100; #1;
      check("lw_ctl", {5'h0, mem_sc, lw, memWE}, 8'h06);
      opcode = 3'b101; #1;
      check("sw_ctl", {5'h0, mem_sc, lw, memWE}, 8'h05);
      check("sw_b_zero", alu_out, 8'hA5);

      // Asynchronous clear mid-cycle, away from any edge.
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async_clear", acc_out, 8'h00);
      opcode = 3'b010; immediate = 5'b00111;
      tick();
      check("rst_prio", acc_out, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check("first_load_post_rst", acc_out, 8'h07);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
